// File: rtl/sobel_frame_sender.sv
// sobel_frame_sender
// Transmit side of the image byte stream: emits a 4-byte header
// {width[7:0], width[15:8], height[7:0], height[15:8]} followed by exactly
// width*height pixel bytes taken from the Sobel stage through a small FIFO,
// paced by the UART transmitter's ready.
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   start               1-cycle frame start pulse, honoured only when idle
//   width, height       frame dimensions, latched on an accepted start
//   data_in/valid_in    pixel stream in; ready_in is the accept handshake
//   data_out/valid_out  registered byte stream out; ready_out from the UART
//   busy                high whenever a frame is in progress
//   done                1-cycle pulse after the last pixel byte transferred
module sobel_frame_sender #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          width,
    input  logic [15:0]          height,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PIXELS,
        S_FINISH
    } state_t;

    state_t               r_state;
    logic [15:0]          r_width;
    logic [15:0]          r_height;
    logic [31:0]          r_total;
    logic [31:0]          r_rx_cnt;
    logic [31:0]          r_tx_cnt;
    logic [1:0]           r_hdr_idx;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_valid_out;
    logic                 r_done;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_tx_fire;
    logic                 w_last_tx;
    logic [7:0]           w_hdr_next;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign ready_in  = ((r_state == S_HEADER) || (r_state == S_PIXELS)) &&
                       !w_full && (r_rx_cnt < r_total);
    assign w_push    = valid_in && ready_in;
    assign w_tx_fire = r_valid_out && ready_out;
    assign w_last_tx = (r_state == S_PIXELS) && (r_tx_cnt == r_total - 32'd1);

    // Pop whenever the output register is free or being emptied this cycle,
    // except after the final pixel: the FIFO can never hold more than total
    // pixels, so that is the only place an extra byte must be held back.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_HEADER: w_pop = w_tx_fire && (r_hdr_idx == 2'd3) && !w_empty;
            S_PIXELS: w_pop = !w_empty &&
                              (!r_valid_out || (ready_out && !w_last_tx));
            default:  w_pop = 1'b0;
        endcase
    end

    // Header byte to present after the transfer of byte r_hdr_idx.
    always_comb begin
        case (r_hdr_idx)
            2'd0:    w_hdr_next = r_width[15:8];
            2'd1:    w_hdr_next = r_height[7:0];
            default: w_hdr_next = r_height[15:8];
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_total     <= '0;
            r_rx_cnt    <= '0;
            r_tx_cnt    <= '0;
            r_hdr_idx   <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_push) r_rx_cnt <= r_rx_cnt + 32'd1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_width     <= width;
                        r_height    <= height;
                        r_total     <= {16'd0, width} * {16'd0, height};
                        r_rx_cnt    <= '0;
                        r_tx_cnt    <= '0;
                        r_hdr_idx   <= '0;
                        r_data_out  <= width[7:0];
                        r_valid_out <= 1'b1;
                        r_state     <= S_HEADER;
                    end
                end

                S_HEADER: begin
                    if (w_tx_fire) begin
                        if (r_hdr_idx != 2'd3) begin
                            r_hdr_idx  <= r_hdr_idx + 2'd1;
                            r_data_out <= w_hdr_next;
                        end else if (r_total == '0) begin
                            r_valid_out <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_FINISH;
                        end else begin
                            r_state <= S_PIXELS;
                            if (w_pop) begin
                                r_data_out <= r_mem[r_rd_ptr];
                            end else begin
                                r_valid_out <= 1'b0;
                            end
                        end
                    end
                end

                S_PIXELS: begin
                    if (w_tx_fire) begin
                        r_tx_cnt <= r_tx_cnt + 32'd1;
                        if (w_last_tx) begin
                            r_valid_out <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_FINISH;
                        end
                    end
                    if (w_pop) begin
                        r_data_out  <= r_mem[r_rd_ptr];
                        r_valid_out <= 1'b1;
                    end else if (w_tx_fire && !w_last_tx) begin
                        r_valid_out <= 1'b0;
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_sobel_frame_sender.sv
// tb_sobel_frame_sender
// Directed bench for sobel_frame_sender. A queue model holds the byte stream
// each frame must produce (header from the frame dimensions, then the pixels
// the bench drives, in order); a negedge monitor checks every output transfer
// against it along with the handshake-stability and quiet-output rules.
module tb_sobel_frame_sender;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] width;
    logic [15:0] height;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_out;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sobel_frame_sender #(
        .DATA_BITS (8),
        .FIFO_DEPTH(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .width    (width),
        .height   (height),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .busy     (busy),
        .done     (done)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  out_log[$];
    int unsigned xfer_cnt = 0;
    int unsigned acc_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned last_xfer_cyc = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    bit          watch_no_ready = 1'b0;
    bit          stop_toggle = 1'b0;

    int unsigned log_base;
    int unsigned xfer_base;
    int unsigned acc_base;
    int unsigned done_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", valid_out, 1);
                check("hold_data", data_out, prev_data);
            end
            if (!busy || done) check("quiet_valid_out", valid_out, 0);
            if (watch_no_ready) check("zero_ready_in", ready_in, 0);
            if (valid_in && ready_in) acc_cnt++;
            if (done) done_cnt++;
            if (valid_out && ready_out) begin
                xfer_cnt++;
                last_xfer_cyc = cyc;
                out_log.push_back(data_out);
                if (exp_q.size() == 0) fail_now("extra_byte");
                else check("stream_byte", data_out, exp_q.pop_front());
            end
            prev_stall = valid_out && !ready_out;
            prev_data  = data_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] got(input int unsigned i);
        return out_log[log_base + i];
    endfunction

    task automatic start_frame(input logic [15:0] w, input logic [15:0] h,
                               input logic [7:0] first, input bit with_pix);
        int unsigned npix;
        npix = w * h;
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(h[7:0]);
        exp_q.push_back(h[15:8]);
        if (with_pix)
            for (int unsigned i = 0; i < npix; i++) exp_q.push_back(first + 8'(i));
        log_base  = out_log.size();
        xfer_base = xfer_cnt;
        acc_base  = acc_cnt;
        done_base = done_cnt;
        start  = 1'b1;
        width  = w;
        height = h;
        tick();
        start  = 1'b0;
        width  = 16'hFFFF;
        height = 16'hFFFF;
        check("start_latency_valid", valid_out, 1);
        check("start_latency_byte", data_out, w[7:0]);
        check("start_busy", busy, 1);
    endtask

    task automatic send_pixel(input logic [7:0] v);
        int unsigned n = 0;
        data_in  = v;
        valid_in = 1'b1;
        while (!ready_in && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) fail_now("send_pixel_timeout");
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", done, 1);
        check("done_after_last_xfer", cyc, last_xfer_cyc + 1);
        tick();
        check("done_single_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("done_pulse_count", done_cnt - done_base, 1);
        check("model_drained", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        ready_out = 1'b0;
        valid_in  = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        rst_n = 1'b0; start = 1'b0; width = '0; height = '0;
        data_in = '0; valid_in = 1'b0; ready_out = 1'b0;
        repeat (3) tick();
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_ready_in", ready_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // T1: header of a 320x240 frame on four consecutive transfers
        ready_out = 1'b1;
        start_frame(16'h0140, 16'h00F0, 8'h00, 1'b0);
        repeat (4) tick();
        check("t1_xfers_consecutive", xfer_cnt - xfer_base, 4);
        check("t1_b0", got(0), 8'h40);
        check("t1_b1", got(1), 8'h01);
        check("t1_b2", got(2), 8'hF0);
        check("t1_b3", got(3), 8'h00);
        pulse_reset();
        check("t1_abort_busy", busy, 0);
        tick();

        // T2: 3x2 frame, pixels 1..6, transmitter always ready; a start
        // and dimension change while busy must be ignored
        ready_out = 1'b1;
        start_frame(16'd3, 16'd2, 8'd1, 1'b1);
        for (int unsigned i = 1; i <= 6; i++) send_pixel(8'(i));
        start = 1'b1; width = 16'd9; height = 16'd9;
        tick();
        start = 1'b0;
        wait_done(200);
        check("t2_len", out_log.size() - log_base, 10);
        check("t2_hdr_w", got(0), 8'd3);
        check("t2_hdr_h", got(2), 8'd2);
        for (int unsigned i = 0; i < 6; i++) check("t2_pix", got(4 + i), i + 1);
        tick();

        // T3: same frame with ready_out 1-on/3-off
        ready_out = 1'b0;
        stop_toggle = 1'b0;
        start_frame(16'd3, 16'd2, 8'd1, 1'b1);
        fork
            begin
                int unsigned k = 0;
                while (!stop_toggle && k < 2000) begin
                    ready_out = (k % 4 == 0);
                    tick();
                    k++;
                end
            end
            begin
                for (int unsigned i = 1; i <= 6; i++) send_pixel(8'(i));
                wait_done(400);
                stop_toggle = 1'b1;
            end
        join
        check("t3_len", out_log.size() - log_base, 10);
        check("t3_last", got(9), 8'd6);
        ready_out = 1'b0;
        tick();

        // T4: 4x8 frame, header stalled, FIFO fills at 16 entries
        ready_out = 1'b0;
        start_frame(16'd4, 16'd8, 8'd1, 1'b1);
        for (int unsigned i = 1; i <= 16; i++) send_pixel(8'(i));
        check("t4_accepted_16", acc_cnt - acc_base, 16);
        for (int unsigned i = 17; i <= 20; i++) begin
            data_in  = 8'(i);
            valid_in = 1'b1;
            check("t4_full_ready_in", ready_in, 0);
            tick();
        end
        valid_in = 1'b0;
        tick();
        check("t4_still_16", acc_cnt - acc_base, 16);
        check("t4_header_stuck", xfer_cnt - xfer_base, 0);
        ready_out = 1'b1;
        for (int unsigned i = 17; i <= 32; i++) send_pixel(8'(i));
        wait_done(500);
        check("t4_len", out_log.size() - log_base, 36);
        check("t4_first_pix", got(4), 8'd1);
        check("t4_last_pix", got(35), 8'd32);
        tick();

        // T5: zero-height frame, header only, ready_in never raised
        ready_out = 1'b1;
        watch_no_ready = 1'b1;
        start_frame(16'd5, 16'd0, 8'd0, 1'b1);
        wait_done(50);
        watch_no_ready = 1'b0;
        check("t5_len", out_log.size() - log_base, 4);
        check("t5_hdr_w", got(0), 8'd5);
        tick();

        // T6: reset right after the second pixel transfer, then a fresh frame
        ready_out = 1'b1;
        start_frame(16'd3, 16'd2, 8'd1, 1'b1);
        fork
            for (int unsigned i = 1; i <= 6; i++) send_pixel(8'(i));
            begin
                n = 0;
                while ((xfer_cnt - xfer_base) < 6 && n < 200) begin
                    tick();
                    n++;
                end
                if (n >= 200) fail_now("t6_wait_timeout");
                pulse_reset();
            end
        join
        check("t6_valid_out", valid_out, 0);
        check("t6_busy", busy, 0);
        check("t6_ready_in", ready_in, 0);
        check("t6_xfers_before_reset", xfer_cnt - xfer_base, 6);
        repeat (3) tick();
        check("t6_no_output_after_reset", xfer_cnt - xfer_base, 6);
        ready_out = 1'b1;
        start_frame(16'd2, 16'd1, 8'h21, 1'b1);
        send_pixel(8'h21);
        send_pixel(8'h22);
        wait_done(200);
        check("t6_len", out_log.size() - log_base, 6);
        check("t6_fresh_hdr", got(0), 8'd2);
        check("t6_fresh_hdr_h", got(2), 8'd1);
        check("t6_pix", got(5), 8'h22);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
